// File: rtl/pwm_decoder_if.sv
// Bus between a PWM source and pwm_decoder: the PWM line plus the decoded measurement results.
interface pwm_decoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pwm_in;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [1:0]       mode;
  logic             stuck;
  logic             period_err;

  modport master (
    output pwm_in,
    input  valid, period, high_time, mode, stuck, period_err
  );

  modport slave (
    input  pwm_in,
    output valid, period, high_time, mode, stuck, period_err
  );
endinterface

// File: rtl/pwm_decoder.sv
// Measures period and high time of a PWM line and classifies the duty into the generator's 2-bit mode.
// Flags stuck-low/stuck-high lines via a timeout, and periods outside the nominal window.
module pwm_decoder #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NOM_PERIOD  = 32,
  parameter int unsigned PERIOD_TOL  = 1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic           clk,
  input  logic           rst,
  pwm_decoder_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // Thresholds are ceilings so that "high < k*P/8" holds exactly for any P.
  localparam int unsigned THR1   = (NOM_PERIOD + 7) / 8;
  localparam int unsigned THR2   = (3 * NOM_PERIOD + 7) / 8;
  localparam int unsigned THR3   = (5 * NOM_PERIOD + 7) / 8;
  localparam int unsigned NOM_LO = (NOM_PERIOD > PERIOD_TOL) ? NOM_PERIOD - PERIOD_TOL : 0;
  localparam int unsigned NOM_HI = NOM_PERIOD + PERIOD_TOL;

  localparam logic [CNT_W-1:0] TO_V     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);
  localparam logic [CNT_W-1:0] THR1_V   = CNT_W'(THR1);
  localparam logic [CNT_W-1:0] THR2_V   = CNT_W'(THR2);
  localparam logic [CNT_W-1:0] THR3_V   = CNT_W'(THR3);
  localparam logic [CNT_W-1:0] NOM_LO_V = CNT_W'(NOM_LO);
  localparam logic [CNT_W-1:0] NOM_HI_V = CNT_W'(NOM_HI);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d;
  logic                   rise, fall, timeout;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt;
  logic [CNT_W-1:0] hi_cap, hi_cap_nxt;

  logic             emit;
  logic [CNT_W-1:0] res_period, res_high;
  logic [1:0]       res_mode;
  logic             res_stuck, res_perr;
  logic [1:0]       cls;
  logic             perr;

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign timeout = (per_cnt == TO_V) & ~rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.pwm_in};
      s_d  <= s;
    end
  end

  // Duty classification of the captured high time.
  always_comb begin
    cls = 2'd3;
    if (hi_cap < THR1_V)      cls = 2'd0;
    else if (hi_cap < THR2_V) cls = 2'd1;
    else if (hi_cap < THR3_V) cls = 2'd2;
  end

  assign perr = (per_cnt < NOM_LO_V) | (per_cnt > NOM_HI_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      hi_cap  <= '0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
      hi_cap  <= hi_cap_nxt;
    end
  end

  // Next state, counters and result payload.
  always_comb begin
    state_nxt  = state;
    per_nxt    = (per_cnt == TO_V) ? per_cnt : per_cnt + ONE_V;
    hi_nxt     = hi_cnt;
    hi_cap_nxt = hi_cap;
    emit       = 1'b0;
    res_period = '0;
    res_high   = '0;
    res_mode   = 2'd0;
    res_stuck  = 1'b0;
    res_perr   = 1'b0;

    if (rise) begin
      per_nxt = ONE_V;
      hi_nxt  = ONE_V;
    end else begin
      if (timeout)           per_nxt = ONE_V;
      if (state == ST_HIGH)  hi_nxt  = hi_cnt + ONE_V;
    end

    if (timeout) begin
      state_nxt = ST_IDLE;
      emit      = 1'b1;
      res_stuck = 1'b1;
      res_perr  = 1'b1;
      res_high  = s ? TO_V : '0;
      res_mode  = s ? 2'd3 : 2'd0;
    end else begin
      case (state)
        ST_IDLE: if (rise) state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (fall) begin
            state_nxt  = ST_LOW;
            hi_cap_nxt = hi_cnt;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_nxt  = ST_HIGH;
            emit       = 1'b1;
            res_period = per_cnt;
            res_high   = hi_cap;
            res_mode   = cls;
            res_perr   = perr;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Results are registered and held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid      <= 1'b0;
      bus.period     <= '0;
      bus.high_time  <= '0;
      bus.mode       <= 2'd0;
      bus.stuck      <= 1'b0;
      bus.period_err <= 1'b0;
    end else begin
      bus.valid <= emit;
      if (emit) begin
        bus.period     <= res_period;
        bus.high_time  <= res_high;
        bus.mode       <= res_mode;
        bus.stuck      <= res_stuck;
        bus.period_err <= res_perr;
      end
    end
  end

endmodule
